// File: rtl/gigatron_cpu.sv
// Gigatron-compatible 8-bit Harvard CPU core: fetch into IR/D, execute from IR/D.
// Every instruction takes one clock and every branch has one delay slot.
module gigatron_cpu (
    input  logic        clock,
    input  logic        rst_n,
    output logic [15:0] pc,
    input  logic [15:0] rom_i,
    output logic [15:0] addr_r,
    output logic [15:0] addr_w,
    input  logic [7:0]  data_i,
    output logic [7:0]  data_o,
    output logic        we,
    output logic [7:0]  out,
    output logic [7:0]  outx
);

    localparam logic [2:0] OP_LD  = 3'd0;
    localparam logic [2:0] OP_AND = 3'd1;
    localparam logic [2:0] OP_OR  = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_ADD = 3'd4;
    localparam logic [2:0] OP_SUB = 3'd5;
    localparam logic [2:0] OP_ST  = 3'd6;
    localparam logic [2:0] OP_BCC = 3'd7;

    localparam logic [7:0] IR_NOP = 8'h02;

    logic [15:0] pc_q, pc_d;
    logic [7:0]  ir_q, ir_d;
    logic [7:0]  d_q, d_d;
    logic [7:0]  ac_q, ac_d;
    logic [7:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    logic [7:0]  out_q, out_d;
    logic [7:0]  outx_q, outx_d;

    logic [2:0]  op;
    logic [2:0]  mode;
    logic [1:0]  bus_sel;
    logic [7:0]  bus_val;
    logic [7:0]  alu;
    logic [15:0] addr;
    logic        is_st;
    logic        is_bcc;
    logic        ac_gt;
    logic        ac_lt;
    logic        ac_eq;
    logic        taken;

    always_comb begin
        op      = ir_q[7:5];
        mode    = ir_q[4:2];
        bus_sel = ir_q[1:0];
        is_st   = (op == OP_ST);
        is_bcc  = (op == OP_BCC);

        // No input port is fitted, so the IN bus source reads as all ones.
        case (bus_sel)
            2'd0:    bus_val = d_q;
            2'd1:    bus_val = data_i;
            2'd2:    bus_val = ac_q;
            default: bus_val = 8'hFF;
        endcase

        if (is_bcc) begin
            addr = {8'h00, d_q};
        end else begin
            case (mode)
                3'd0:    addr = {8'h00, d_q};
                3'd1:    addr = {8'h00, x_q};
                3'd2:    addr = {y_q, d_q};
                3'd3:    addr = {y_q, x_q};
                3'd7:    addr = {y_q, x_q};
                default: addr = {8'h00, d_q};
            endcase
        end

        case (op)
            OP_LD:   alu = bus_val;
            OP_AND:  alu = ac_q & bus_val;
            OP_OR:   alu = ac_q | bus_val;
            OP_XOR:  alu = ac_q ^ bus_val;
            OP_ADD:  alu = ac_q + bus_val;
            OP_SUB:  alu = ac_q - bus_val;
            default: alu = ac_q;
        endcase

        ac_lt = ac_q[7];
        ac_eq = (ac_q == 8'h00);
        ac_gt = !ac_lt && !ac_eq;
        taken = (mode[0] && ac_gt) || (mode[1] && ac_lt) || (mode[2] && ac_eq);
    end

    always_comb begin
        ir_d   = rom_i[7:0];
        d_d    = rom_i[15:8];
        pc_d   = pc_q + 16'd1;
        ac_d   = ac_q;
        x_d    = x_q;
        y_d    = y_q;
        out_d  = out_q;
        outx_d = outx_q;

        if (is_bcc) begin
            // pc_q already points at the delay slot, so near branches stay in its page.
            if (mode == 3'd0) begin
                pc_d = {y_q, bus_val};
            end else if (taken) begin
                pc_d = {pc_q[15:8], bus_val};
            end
        end else begin
            case (mode)
                3'd4: x_d = alu;
                3'd5: y_d = alu;
                3'd6: begin
                    if (!is_st) out_d = alu;
                end
                3'd7: begin
                    if (!is_st) out_d = alu;
                    x_d = x_q + 8'd1;
                end
                default: begin
                    if (!is_st) ac_d = alu;
                end
            endcase
        end

        // Latch the pre-instruction accumulator on the hsync rising edge of OUT.
        if (out_d[6] && !out_q[6]) begin
            outx_d = ac_q;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= 16'h0000;
            ir_q   <= IR_NOP;
            d_q    <= 8'h00;
            ac_q   <= 8'h00;
            x_q    <= 8'h00;
            y_q    <= 8'h00;
            out_q  <= 8'h00;
            outx_q <= 8'h00;
        end else begin
            pc_q   <= pc_d;
            ir_q   <= ir_d;
            d_q    <= d_d;
            ac_q   <= ac_d;
            x_q    <= x_d;
            y_q    <= y_d;
            out_q  <= out_d;
            outx_q <= outx_d;
        end
    end

    assign pc     = pc_q;
    assign addr_r = addr;
    assign addr_w = addr;
    assign data_o = bus_val;
    assign we     = is_st;
    assign out    = out_q;
    assign outx   = outx_q;

endmodule

// File: tb/tb_gigatron_cpu.sv
// Directed bench for gigatron_cpu with behavioural ROM and RAM around the core.
module tb_gigatron_cpu;

    logic        clock;
    logic        rst_n;
    logic [15:0] pc;
    logic [15:0] rom_i;
    logic [15:0] addr_r;
    logic [15:0] addr_w;
    logic [7:0]  data_i;
    logic [7:0]  data_o;
    logic        we;
    logic [7:0]  out;
    logic [7:0]  outx;

    logic [15:0] rom [0:65535];
    logic [7:0]  ram [0:65535];

    int n_checks = 0;
    int n_fail   = 0;

    gigatron_cpu dut (
        .clock  (clock),
        .rst_n  (rst_n),
        .pc     (pc),
        .rom_i  (rom_i),
        .addr_r (addr_r),
        .addr_w (addr_w),
        .data_i (data_i),
        .data_o (data_o),
        .we     (we),
        .out    (out),
        .outx   (outx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign rom_i  = rom[pc];
    assign data_i = ram[addr_r];

    always @(posedge clock) begin
        if (we) ram[addr_w] <= data_o;
    end

    task automatic clear_rom();
        for (int i = 0; i < 65536; i++) rom[i] = 16'h0002;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_rom();
        rst_n = 1'b0;
        @(negedge clock);
        n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc got %h want 0000", pc); end
        n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", we); end
        n_checks++; if (out !== 8'h00) begin n_fail++; $display("FAIL reset_out got %h want 00", out); end
        n_checks++; if (outx !== 8'h00) begin n_fail++; $display("FAIL reset_outx got %h want 00", outx); end
        n_checks++; if (addr_r !== 16'h0000) begin n_fail++; $display("FAIL reset_addr got %h want 0000", addr_r); end
        n_checks++; if (data_o !== 8'h00) begin n_fail++; $display("FAIL reset_bus_ac got %h want 00", data_o); end
        rst_n = 1'b1;
    endtask

    task automatic test_alu_store();
        clear_rom();
        rom[0] = 16'h5A00;  // ld $5A
        rom[1] = 16'h0380;  // add $03
        rom[2] = 16'h4010;  // ld $40,X
        rom[3] = 16'h10C2;  // st [$10]
        rom[4] = 16'h0000;  // ld $00
        rom[5] = 16'h1001;  // ld [$10]
        rom[6] = 16'h00C6;  // st [X]
        do_reset();
        n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL seq_pc0 got %h want 0000", pc); end
        step(1);
        n_checks++; if (pc !== 16'h0001) begin n_fail++; $display("FAIL seq_pc1 got %h want 0001", pc); end
        step(1);
        n_checks++; if (pc !== 16'h0002) begin n_fail++; $display("FAIL seq_pc2 got %h want 0002", pc); end
        step(1);
        n_checks++; if (pc !== 16'h0003) begin n_fail++; $display("FAIL seq_pc3 got %h want 0003", pc); end
        step(1);
        n_checks++; if (we !== 1'b1) begin n_fail++; $display("FAIL st_we got %b want 1", we); end
        n_checks++; if (addr_w !== 16'h0010) begin n_fail++; $display("FAIL st_addr got %h want 0010", addr_w); end
        n_checks++; if (data_o !== 8'h5D) begin n_fail++; $display("FAIL st_data got %h want 5D", data_o); end
        step(1);
        n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL ld_we got %b want 0", we); end
        step(1);
        n_checks++; if (data_i !== 8'h5D) begin n_fail++; $display("FAIL ram_read got %h want 5D", data_i); end
        step(1);
        n_checks++; if (addr_w !== 16'h0040) begin n_fail++; $display("FAIL st_x_addr got %h want 0040", addr_w); end
        n_checks++; if (data_o !== 8'h5D) begin n_fail++; $display("FAIL reload_ac got %h want 5D", data_o); end
    endtask

    task automatic test_jmp_delay();
        clear_rom();
        rom[0]        = 16'h1214;  // ld $12,Y
        rom[1]        = 16'h34E0;  // jmp Y,$34
        rom[2]        = 16'h0700;  // ld $07 (delay slot)
        rom[16'h1234] = 16'h00C2;  // st [$00]
        do_reset();
        step(2);
        n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL jmp_we got %b want 0", we); end
        step(1);
        n_checks++; if (pc !== 16'h1234) begin n_fail++; $display("FAIL jmp_target got %h want 1234", pc); end
        step(1);
        n_checks++; if (data_o !== 8'h07) begin n_fail++; $display("FAIL slot_ac got %h want 07", data_o); end
        n_checks++; if (pc !== 16'h1235) begin n_fail++; $display("FAIL after_target got %h want 1235", pc); end
    endtask

    task automatic run_branch(input logic [7:0] ac_val, input logic [7:0] br_ir, input logic [15:0] want_pc);
        clear_rom();
        rom[0]        = 16'h0514;            // ld $05,Y
        rom[1]        = 16'h00E0;            // jmp Y,$00
        rom[2]        = {ac_val, 8'h00};     // ld ac_val (delay slot)
        rom[16'h0500] = {8'h40, br_ir};      // bcc $40
        do_reset();
        step(3);
        n_checks++; if (pc !== 16'h0500) begin n_fail++; $display("FAIL br_setup_%h got %h want 0500", br_ir, pc); end
        step(2);
        n_checks++; if (pc !== want_pc) begin n_fail++; $display("FAIL br_%h_ac%h got %h want %h", br_ir, ac_val, pc, want_pc); end
    endtask

    task automatic test_conditional();
        run_branch(8'h80, 8'hE8, 16'h0540);  // blt taken
        run_branch(8'h80, 8'hF4, 16'h0502);  // bge not taken
        run_branch(8'h00, 8'hF0, 16'h0540);  // beq taken
        run_branch(8'h00, 8'hEC, 16'h0502);  // bne not taken
        run_branch(8'h01, 8'hE4, 16'h0540);  // bgt taken
        run_branch(8'h01, 8'hE8, 16'h0502);  // blt not taken
        run_branch(8'hFF, 8'hF8, 16'h0540);  // ble taken
    endtask

    task automatic test_out_xinc();
        clear_rom();
        rom[0] = 16'h0814;  // ld $08,Y
        rom[1] = 16'hFF10;  // ld $FF,X
        rom[2] = 16'h001D;  // ld [Y,X++],OUT
        rom[3] = 16'h00C6;  // st [X]
        do_reset();
        ram[16'h08FF] <= 8'hA7;
        step(3);
        n_checks++; if (addr_r !== 16'h08FF) begin n_fail++; $display("FAIL xinc_addr got %h want 08FF", addr_r); end
        step(1);
        n_checks++; if (out !== 8'hA7) begin n_fail++; $display("FAIL xinc_out got %h want A7", out); end
        n_checks++; if (addr_w !== 16'h0000) begin n_fail++; $display("FAIL xinc_wrap got %h want 0000", addr_w); end
        n_checks++; if (outx !== 8'h00) begin n_fail++; $display("FAIL xinc_outx got %h want 00", outx); end
    endtask

    task automatic test_outx();
        clear_rom();
        rom[0] = 16'h3C00;  // ld $3C
        rom[1] = 16'h4018;  // ld $40,OUT
        rom[2] = 16'h5500;  // ld $55
        rom[3] = 16'h4018;  // ld $40,OUT
        rom[4] = 16'h0018;  // ld $00,OUT
        rom[5] = 16'h4018;  // ld $40,OUT
        do_reset();
        step(3);
        n_checks++; if (out !== 8'h40) begin n_fail++; $display("FAIL outx_out got %h want 40", out); end
        n_checks++; if (outx !== 8'h3C) begin n_fail++; $display("FAIL outx_rise got %h want 3C", outx); end
        step(2);
        n_checks++; if (outx !== 8'h3C) begin n_fail++; $display("FAIL outx_hold got %h want 3C", outx); end
        step(1);
        n_checks++; if (out !== 8'h00) begin n_fail++; $display("FAIL outx_clear got %h want 00", out); end
        step(1);
        n_checks++; if (outx !== 8'h55) begin n_fail++; $display("FAIL outx_rise2 got %h want 55", outx); end
    endtask

    task automatic test_reset_abort();
        clear_rom();
        rom[0] = 16'h10C0;  // st $10 -> [$10]
        do_reset();
        ram[16'h0010] <= 8'h77;
        step(1);
        n_checks++; if (we !== 1'b1) begin n_fail++; $display("FAIL abort_pre_we got %b want 1", we); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL abort_we got %b want 0", we); end
        n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL abort_pc got %h want 0000", pc); end
        @(posedge clock);
        #1;
        n_checks++; if (ram[16'h0010] !== 8'h77) begin n_fail++; $display("FAIL abort_ram got %h want 77", ram[16'h0010]); end
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_alu_store();
        test_jmp_delay();
        test_conditional();
        test_out_xinc();
        test_outx();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gigatron_cpu.md
Name: gigatron_cpu

Overview:
- 8-bit Gigatron-compatible TTL-style CPU core with Harvard architecture.
- 16-bit instruction ROM and 8-bit data RAM, both external and read asynchronously.
- Two-stage pipeline: fetch, then execute. Every instruction takes one clock; each branch has one delay slot.
- Drives the video/sound OUT port and the extended OUTX port at the top of the system.

Parameters:
- None.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pc  out  16  ROM fetch address; equals the program-counter register.
- rom_i  in  16  instruction word at pc, combinational. [7:0] = opcode IR, [15:8] = operand D.
- addr_r  out  16  RAM read address, combinational from the execute stage.
- addr_w  out  16  RAM write address; same value as addr_r.
- data_i  in  8  RAM[addr_r], asynchronous read.
- data_o  out  8  RAM write data; equals the bus value.
- we  out  1  RAM write enable; the external RAM writes on the clock edge.
- out  out  8  OUT register.
- outx  out  8  extended output register.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc=0000, IR=02 (nop), D=00.
  - AC, X, Y, out, outx = 00; we=0.
- Every cycle:
  - IR and D are loaded from rom_i.
  - pc is loaded with pc+1, or with the branch target when a branch is taken.
  - The instruction in IR executes in that same cycle.
  - Delay slot: the word at branch address+1 always executes.
- Decode:
  - op = IR[7:5]: 0 LD, 1 AND, 2 OR, 3 XOR, 4 ADD, 5 SUB, 6 ST, 7 Bcc.
  - mode = IR[4:2].
  - bus = IR[1:0].
- Bus value B:
  - bus 0 → D; 1 → data_i; 2 → AC; 3 → IN, fixed at FF because there is no input port.
  - For ST with bus=1, B = data_i.
- Address and destination for non-branch ops, by mode:
  - 0: address 00:D, destination AC.
  - 1: address 00:X, destination AC.
  - 2: address Y:D, destination AC.
  - 3: address Y:X, destination AC.
  - 4: address 00:D, destination X.
  - 5: address 00:D, destination Y.
  - 6: address 00:D, destination OUT.
  - 7: address Y:X, destination OUT; X increments by 1 after the access (8-bit wrap).
  - For Bcc, the address is always 00:D.
- ALU (8-bit, wrap-around, no flags):
  - LD: B; AND: AC&B; OR: AC|B; XOR: AC^B.
  - ADD: AC+B; SUB: AC-B.
  - ST: passes AC.
- ST:
  - we=1 and data_o=B, written to the mode address.
  - AC and OUT are not written.
  - Modes 4 and 5 still load X or Y with AC.
  - If X++ (mode 7) also loads X, the increment has priority.
- Bcc:
  - No register is written; we=0.
  - mode 0 (jmp): pc <= Y:B.
  - Modes 1–7: conditional near branch, pc <= {pc[15:8], B}, using the pc value during execute.
  - Condition: mode bit0 takes the branch if AC>0 (signed), bit1 if AC<0, bit2 if AC==0.
  - Resulting set: 1 bgt, 2 blt, 3 bne, 4 beq, 5 bge, 6 ble, 7 bra.
- OUTX: when out changes from bit6=0 to bit6=1 (hsync rising), outx <= AC, using the AC value before this instruction.
- we is 0 for every op other than ST.
- Reset asserted mid-operation aborts immediately; no partial write is permitted after the edge.

Test Plan:
- Reset, then ROM[0]=(D=5A, ld $5A: IR=00) and ROM[1]=(IR=80, D=03: add $03) → after 2 execute cycles AC=5D; pc sequence 0,1,2,3.
- Store: with AC=5D, run ld $40,X (IR=10, D=40) then st [$10] (IR=C2, D=10) → we=1, addr_w=0010, data_o=5D; next ld [$10] gives AC=5D.
- Branch delay slot: jmp via Y=12, B=34, with ld $07 in the slot → slot executes, AC=07; next pc=1234.
- Conditionals:
  - AC=80: blt taken, bge not taken.
  - AC=00: beq taken, bne not taken.
  - AC=01: bgt taken.
  - In every taken case the target high byte equals the pc high byte.
- OUT with X++: Y=08, X=FF, ld [Y,X++],OUT → addr_r=08FF, out=RAM[08FF], X=00.
- OUTX: AC=3C, out 00→40 → outx=3C; with out already 40, a further write of 40 leaves outx unchanged.
